// File: rtl/mem_access_unit.sv
// Memory-side stage for the multicycle core: turns level control lines into a
// req/ack memory transaction and owns the IR and MDR.
module mem_access_unit #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              IorD_ctrl,
  input  logic              MemRead_ctrl,
  input  logic              MemWrite_ctrl,
  input  logic              IRWrite_ctrl,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_reg,
  output logic [5:0]        opcode,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  // Last REQ cycle index that may still wait for ack.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ir_en;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdr;
  logic              r_err;

  logic              w_idle, w_in_req;
  logic              w_start_rd, w_start_wr, w_conflict, w_timeout;
  logic [ADDR_W-1:0] w_sel_addr, w_addr;

  assign w_idle     = (r_state == S_IDLE);
  assign w_in_req   = (r_state == S_REQ);
  assign w_start_rd = w_idle &  MemRead_ctrl & ~MemWrite_ctrl;
  assign w_start_wr = w_idle & ~MemRead_ctrl &  MemWrite_ctrl;
  assign w_conflict = w_idle &  MemRead_ctrl &  MemWrite_ctrl;
  assign w_timeout  = w_in_req & ~mem_ack & (r_cnt == TO_LAST);
  assign w_sel_addr = IorD_ctrl ? alu_out : pc;
  assign w_addr     = {w_sel_addr[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_conflict)                   w_next = S_ERR;
        else if (w_start_rd | w_start_wr) w_next = S_REQ;
      end
      S_REQ: begin
        if (mem_ack)        w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, wait counter and IR/MDR capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_ir_en <= 1'b0;
      r_cnt   <= '0;
      r_ir    <= '0;
      r_mdr   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_start_rd | w_start_wr) begin
        r_addr  <= w_addr;
        r_we    <= w_start_wr;
        r_ir_en <= w_start_rd & IRWrite_ctrl;
        r_cnt   <= '0;
        if (w_start_wr) r_wdata <= wr_data;
      end
      if (w_in_req) begin
        if (mem_ack) begin
          if (!r_we) begin
            r_mdr <= mem_rdata;
            if (r_ir_en) r_ir <= mem_rdata;
          end
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
      if (w_conflict | w_timeout) r_err <= 1'b1;
    end
  end

  assign mem_req   = w_in_req;
  assign busy      = w_in_req;
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign instr_reg = r_ir;
  assign opcode    = r_ir[DATA_W-1 -: 6];
  assign mdr       = r_mdr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; a negedge monitor scores done/err events
// against an expected-response queue filled by the stimulus.
module tb_mem_access_unit;

  logic        clock, reset;
  logic [31:0] pc, alu_out, wr_data;
  logic        IorD_ctrl, MemRead_ctrl, MemWrite_ctrl, IRWrite_ctrl;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] instr_reg, mdr;
  logic [5:0]  opcode;
  logic        busy, done, err;

  typedef struct {
    logic        is_err;
    logic [31:0] ir;
    logic [31:0] mdr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic err_prev = 1'b0;

  mem_access_unit dut (
    .clock(clock), .reset(reset), .pc(pc), .alu_out(alu_out), .wr_data(wr_data),
    .IorD_ctrl(IorD_ctrl), .MemRead_ctrl(MemRead_ctrl), .MemWrite_ctrl(MemWrite_ctrl),
    .IRWrite_ctrl(IRWrite_ctrl), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr_reg(instr_reg), .opcode(opcode), .mdr(mdr),
    .busy(busy), .done(done), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic is_err, input logic [31:0] ir, input logic [31:0] m);
    exp_t e;
    e.is_err = is_err; e.ir = ir; e.mdr = m;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every done pulse or err rising edge consumes one entry.
  always @(negedge clock) begin
    exp_t e;
    if (done || (err && !err_prev)) begin
      if (exp_q.size() == 0) begin
        chk(done ? "unexpected_done" : "unexpected_err", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", {31'd0, err && !err_prev && !done}, {31'd0, e.is_err});
        chk("sb_instr_reg", instr_reg, e.ir);
        chk("sb_mdr", mdr, e.mdr);
        chk("sb_opcode", {26'd0, opcode}, {26'd0, e.ir[31:26]});
      end
    end
    err_prev = err;
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic idle_ctrl();
    MemRead_ctrl = 0; MemWrite_ctrl = 0; IRWrite_ctrl = 0; IorD_ctrl = 0;
    pc = 32'hFFFF_FFF0; alu_out = 32'hEEEE_EEE0; wr_data = 32'h5A5A_5A5A;
  endtask

  // Issue one transaction, ack after 'waits' extra REQ cycles, check bus and done.
  task automatic txn(input logic iord, input logic rd, input logic wr, input logic irw,
                     input logic [31:0] p, input logic [31:0] a, input logic [31:0] wd,
                     input int waits, input logic [31:0] rdata,
                     input logic [31:0] exp_addr, input string nm);
    IorD_ctrl = iord; MemRead_ctrl = rd; MemWrite_ctrl = wr; IRWrite_ctrl = irw;
    pc = p; alu_out = a; wr_data = wd;
    @(posedge clock); #1;
    idle_ctrl();
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      chk({nm, "_req"}, {31'd0, mem_req}, 32'd1);
      chk({nm, "_addr"}, mem_addr, exp_addr);
      chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, wr});
      if (wr) chk({nm, "_wdata"}, mem_wdata, wd);
      @(posedge clock); #1;
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clock);
    chk({nm, "_req_at_ack"}, {31'd0, mem_req}, 32'd1);
    chk({nm, "_addr_at_ack"}, mem_addr, exp_addr);
    @(posedge clock); #1;
    mem_ack = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clock);
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_req_off"}, {31'd0, mem_req}, 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk({nm, "_done_1cyc"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int reqcnt;
    mem_ack = 0; mem_rdata = 0; reset = 1'b1;
    idle_ctrl();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ir", instr_reg, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_mdr", mdr, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);

    // Fetch: ack in 4th REQ cycle.
    push(0, 32'h8400_0010, 32'h8400_0010);
    txn(0, 1, 0, 1, 32'h0000_0008, 32'h0, 32'h0, 3, 32'h8400_0010, 32'h0000_0008, "fetch");
    chk("fetch_opcode", {26'd0, opcode}, {26'd0, 6'b100001});

    // Data load, same-cycle ack, unaligned address.
    push(0, 32'h8400_0010, 32'hDEAD_BEEF);
    txn(1, 1, 0, 0, 32'h0, 32'h0000_0103, 32'h0, 0, 32'hDEAD_BEEF, 32'h0000_0100, "load");

    // Store: data registers untouched even though rdata is driven.
    push(0, 32'h8400_0010, 32'hDEAD_BEEF);
    txn(1, 0, 1, 0, 32'h0, 32'h0000_0020, 32'h1234_5678, 2, 32'h7777_7777, 32'h0000_0020, "store");

    // Ack while idle is ignored.
    @(posedge clock); #1; mem_ack = 1; mem_rdata = 32'hAAAA_AAAA;
    @(posedge clock); #1; mem_ack = 0;
    @(negedge clock);
    chk("idle_ack_mdr", mdr, 32'hDEAD_BEEF);
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);

    // Timeout.
    push(1, 32'h8400_0010, 32'hDEAD_BEEF);
    MemRead_ctrl = 1;
    @(posedge clock); #1;
    idle_ctrl();
    reqcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mem_req) reqcnt++;
      else break;
    end
    chk("timeout_req_cycles", reqcnt, 32'd15);
    chk("timeout_err", {31'd0, err}, 32'd1);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF; MemRead_ctrl = 1;
    @(posedge clock); #1; mem_ack = 0;
    @(posedge clock); #1; MemRead_ctrl = 0;
    @(negedge clock);
    chk("late_ack_mdr", mdr, 32'hDEAD_BEEF);
    chk("err_state_req", {31'd0, mem_req}, 32'd0);
    chk("err_state_done", {31'd0, done}, 32'd0);
    chk("err_sticky", {31'd0, err}, 32'd1);
    do_reset();
    @(negedge clock);
    chk("reset_clears_err", {31'd0, err}, 32'd0);

    // Conflict: both read and write.
    push(1, 32'h0, 32'h0);
    MemRead_ctrl = 1; MemWrite_ctrl = 1;
    reqcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (mem_req) reqcnt++;
    end
    idle_ctrl();
    @(negedge clock);
    chk("conflict_no_req", reqcnt, 32'd0);
    chk("conflict_err", {31'd0, err}, 32'd1);
    do_reset();

    // Reset mid-REQ after loading a non-zero IR.
    push(0, 32'hFC00_0001, 32'hFC00_0001);
    txn(0, 1, 0, 1, 32'h0000_0010, 32'h0, 32'h0, 1, 32'hFC00_0001, 32'h0000_0010, "fetch2");
    chk("fetch2_opcode", {26'd0, opcode}, {26'd0, 6'b111111});
    MemRead_ctrl = 1; IRWrite_ctrl = 1; pc = 32'h0000_0040;
    @(posedge clock); #1;
    idle_ctrl();
    @(negedge clock);
    chk("mid_req_c1", {31'd0, mem_req}, 32'd1);
    @(posedge clock); #1; reset = 1;
    @(negedge clock);
    chk("mid_req_c2", {31'd0, mem_req}, 32'd1);
    @(posedge clock); #1; reset = 0; mem_ack = 1; mem_rdata = 32'h1111_1111;
    @(negedge clock);
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_ir", instr_reg, 32'd0);
    chk("rst_mid_opcode", {26'd0, opcode}, 32'd0);
    @(posedge clock); #1; mem_ack = 0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("rst_mid_mdr", mdr, 32'd0);
    chk("rst_mid_ir_hold", instr_reg, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage between the multicycle controller and the unified instruction/data memory.
- Converts the controller's level control lines (IorD, MemRead, MemWrite, IRWrite) into a req/ack transaction with wait states.
- Holds the Instruction Register (IR) and the Memory Data Register (MDR); the IR opcode field drives the controller's opcode input.
- Reports busy/done so the datapath wrapper can stall the controller, and flags timeouts and protocol errors.

Parameters:
- DATA_W, 32, data and instruction width.
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 15, cycles in REQ without mem_ack before abort (1..255).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- pc  in  ADDR_W  program counter; fetch address
- alu_out  in  ADDR_W  ALUOut register; data address
- wr_data  in  DATA_W  store data (rt register value)
- IorD_ctrl  in  1  0 = address from pc, 1 = address from alu_out
- MemRead_ctrl  in  1  read request
- MemWrite_ctrl  in  1  write request
- IRWrite_ctrl  in  1  read data also loads IR
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write transaction
- mem_addr  out  ADDR_W  word-aligned address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  DATA_W  read data, valid while mem_ack is high
- instr_reg  out  DATA_W  IR contents
- opcode  out  6  instr_reg[31:26], to controller
- mdr  out  DATA_W  MDR contents
- busy  out  1  transaction in progress (REQ)
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: timeout or MemRead and MemWrite both high

Behaviour:
Reset:
- All outputs 0, including instr_reg, so opcode is 000000 (NOOP) and the controller idles.
- FSM goes to IDLE; timeout counter is cleared.
- Reset asserted mid-transaction: mem_req drops at the next edge, and any ack arriving later is ignored.

States: IDLE, REQ, DONE, ERR.

IDLE:
- MemWrite only: latch addr, we = 1, wdata = wr_data, then go to REQ.
- MemRead only: latch addr, we = 0, and latch IRWrite_ctrl into ir_en, then go to REQ.
- Both MemRead and MemWrite high: set err, go to ERR, issue no transaction.
- Neither high: stay in IDLE.
- Address is IorD_ctrl ? alu_out : pc, with bits [1:0] forced to 0.
- mem_ack seen in IDLE is ignored.

REQ:
- mem_req = 1 and busy = 1; mem_addr, mem_we and mem_wdata are stable from the latched values.
- mem_ack high on a read: mdr <= mem_rdata; if ir_en, also instr_reg <= mem_rdata. Go to DONE.
- mem_ack high on a write: no register updates. Go to DONE.
- Counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES: set err, drop mem_req, go to ERR.
- Control-input changes during REQ are ignored.

DONE:
- done = 1 for exactly one cycle; mem_req = 0.
- Next state is IDLE. If the controls are still asserted in IDLE, a new transaction starts; the controller must leave that state on done.

ERR:
- mem_req = 0, busy = 0, err = 1; stays in ERR until reset.
- mem_ack in ERR is ignored.

Latency:
- Request sampled at edge N; mem_req is high from N+1.
- Ack at cycle M (M >= N+1) gives data in IR/MDR and done at M+1.
- Minimum is 2 cycles from request to done.

Other rules:
- IR and MDR hold their values between transactions.
- An IR load affects opcode in the same cycle the IR updates.

Test Plan:
- Fetch: pc=0x0000_0008, IorD=0, MemRead=1, IRWrite=1; ack 3 cycles after mem_req with rdata=0x8400_0010 -> mem_addr=0x08 while mem_req high; instr_reg=0x8400_0010, opcode=6'b100001 and done pulse on the cycle after ack.
- Data load: alu_out=0x0000_0103, IorD=1, MemRead=1, IRWrite=0; same-cycle ack with rdata=0xDEAD_BEEF -> mem_addr=0x100; mdr=0xDEAD_BEEF; instr_reg unchanged; done 2 cycles after request.
- Store: alu_out=0x20, wr_data=0x1234_5678, MemWrite=1 -> mem_we=1, mem_wdata=0x1234_5678 stable until ack; mdr and IR unchanged; one done pulse.
- Timeout: MemRead=1, never ack -> mem_req high exactly 15 cycles, then err=1, FSM in ERR; a late ack has no effect; reset clears err.
- Conflict: MemRead=1 and MemWrite=1 in IDLE -> err=1, mem_req never asserted.
- Reset mid-REQ: assert reset on the 2nd wait cycle, then ack -> mem_req=0 after the edge; instr_reg=0, opcode=0; ack ignored; no done pulse.
